// File: rtl/alu_rs.sv
// Integer ALU reservation station.
// Holds dispatched ALU-class instructions until both source operands are
// known. It captures operands from the ALU and LSB result buses by ROB tag
// and issues the lowest-index ready entry to the ALU, at most one per cycle.
module alu_rs #(
    parameter int RS_SIZE     = 16,
    parameter int RS_IDX_WID  = 4,
    parameter int ROB_TAG_WID = 4,
    parameter int DATA_WID    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    input  logic                   issue_en,
    input  logic [6:0]             issue_opcode,
    input  logic [2:0]             issue_funct3,
    input  logic                   issue_funct7,
    input  logic                   issue_has_dep1,
    input  logic [ROB_TAG_WID-1:0] issue_q1,
    input  logic [DATA_WID-1:0]    issue_val1,
    input  logic                   issue_has_dep2,
    input  logic [ROB_TAG_WID-1:0] issue_q2,
    input  logic [DATA_WID-1:0]    issue_val2,
    input  logic [DATA_WID-1:0]    issue_imm,
    input  logic [ROB_TAG_WID-1:0] issue_rob_pos,
    input  logic [DATA_WID-1:0]    issue_pc,
    input  logic                   alu_res_done,
    input  logic [ROB_TAG_WID-1:0] alu_res_rob_pos,
    input  logic [DATA_WID-1:0]    alu_res_val,
    input  logic                   lsb_res_done,
    input  logic [ROB_TAG_WID-1:0] lsb_res_rob_pos,
    input  logic [DATA_WID-1:0]    lsb_res_val,
    output logic                   rs_full,
    output logic                   alu_en,
    output logic [6:0]             alu_opcode,
    output logic [2:0]             alu_funct3,
    output logic                   alu_funct7,
    output logic [DATA_WID-1:0]    alu_val1,
    output logic [DATA_WID-1:0]    alu_val2,
    output logic [DATA_WID-1:0]    alu_imm,
    output logic [DATA_WID-1:0]    alu_pc,
    output logic [ROB_TAG_WID-1:0] alu_rob_pos
);

    localparam logic [RS_IDX_WID:0] ONE_COUNT  = (RS_IDX_WID + 1)'(1);
    localparam logic [RS_IDX_WID:0] FULL_COUNT = (RS_IDX_WID + 1)'(RS_SIZE);

    // Per-entry storage
    logic [RS_SIZE-1:0]     busy_q;
    logic [RS_SIZE-1:0]     dep1_q;
    logic [RS_SIZE-1:0]     dep2_q;
    logic [6:0]             opcode_q [RS_SIZE];
    logic [2:0]             funct3_q [RS_SIZE];
    logic                   funct7_q [RS_SIZE];
    logic [ROB_TAG_WID-1:0] q1_q     [RS_SIZE];
    logic [ROB_TAG_WID-1:0] q2_q     [RS_SIZE];
    logic [DATA_WID-1:0]    val1_q   [RS_SIZE];
    logic [DATA_WID-1:0]    val2_q   [RS_SIZE];
    logic [DATA_WID-1:0]    imm_q    [RS_SIZE];
    logic [DATA_WID-1:0]    pc_q     [RS_SIZE];
    logic [ROB_TAG_WID-1:0] robPos_q [RS_SIZE];

    // Occupancy and output registers
    logic [RS_IDX_WID:0]    count_q, count_d;
    logic                   rsFull_q;
    logic                   aluEn_q;
    logic [6:0]             aluOpcode_q;
    logic [2:0]             aluFunct3_q;
    logic                   aluFunct7_q;
    logic [DATA_WID-1:0]    aluVal1_q, aluVal2_q, aluImm_q, aluPc_q;
    logic [ROB_TAG_WID-1:0] aluRobPos_q;

    // Selection and insert-path signals
    logic                   freeFound, readyFound;
    logic [RS_IDX_WID-1:0]  freeIdx, readyIdx;
    logic                   insertEn, issueEn;
    logic                   insDep1_d, insDep2_d;
    logic [DATA_WID-1:0]    insVal1_d, insVal2_d;

    // Priority-encode the lowest free slot and the lowest ready slot.
    // The scan runs from high to low so that the last hit is the lowest index.
    always_comb begin
        freeFound  = 1'b0;
        freeIdx    = '0;
        readyFound = 1'b0;
        readyIdx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = RS_IDX_WID'(i);
            end
            if (busy_q[i] && !dep1_q[i] && !dep2_q[i]) begin
                readyFound = 1'b1;
                readyIdx   = RS_IDX_WID'(i);
            end
        end
    end

    // Resolve the incoming operands against the same-cycle result buses.
    // When both buses match, the ALU value is taken.
    always_comb begin
        insDep1_d = issue_has_dep1;
        insVal1_d = issue_val1;
        insDep2_d = issue_has_dep2;
        insVal2_d = issue_val2;
        if (issue_has_dep1) begin
            if (alu_res_done && alu_res_rob_pos == issue_q1) begin
                insDep1_d = 1'b0;
                insVal1_d = alu_res_val;
            end else if (lsb_res_done && lsb_res_rob_pos == issue_q1) begin
                insDep1_d = 1'b0;
                insVal1_d = lsb_res_val;
            end
        end
        if (issue_has_dep2) begin
            if (alu_res_done && alu_res_rob_pos == issue_q2) begin
                insDep2_d = 1'b0;
                insVal2_d = alu_res_val;
            end else if (lsb_res_done && lsb_res_rob_pos == issue_q2) begin
                insDep2_d = 1'b0;
                insVal2_d = lsb_res_val;
            end
        end
    end

    // Next occupancy. A drop (issue_en with no free slot) leaves it unchanged.
    always_comb begin
        insertEn = issue_en && freeFound;
        issueEn  = readyFound;
        count_d  = count_q;
        if (insertEn && !issueEn) begin
            count_d = count_q + ONE_COUNT;
        end else if (!insertEn && issueEn) begin
            count_d = count_q - ONE_COUNT;
        end
    end

    // Entry updates: wakeup, insert and issue. Flush clears busy and outputs;
    // rdy low freezes everything.
    always_ff @(posedge clk) begin
        if (rst || rollback) begin
            busy_q      <= '0;
            count_q     <= '0;
            rsFull_q    <= 1'b0;
            aluEn_q     <= 1'b0;
            aluOpcode_q <= '0;
            aluFunct3_q <= '0;
            aluFunct7_q <= 1'b0;
            aluVal1_q   <= '0;
            aluVal2_q   <= '0;
            aluImm_q    <= '0;
            aluPc_q     <= '0;
            aluRobPos_q <= '0;
        end else if (rdy) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && dep1_q[i]) begin
                    if (alu_res_done && alu_res_rob_pos == q1_q[i]) begin
                        dep1_q[i] <= 1'b0;
                        val1_q[i] <= alu_res_val;
                    end else if (lsb_res_done && lsb_res_rob_pos == q1_q[i]) begin
                        dep1_q[i] <= 1'b0;
                        val1_q[i] <= lsb_res_val;
                    end
                end
                if (busy_q[i] && dep2_q[i]) begin
                    if (alu_res_done && alu_res_rob_pos == q2_q[i]) begin
                        dep2_q[i] <= 1'b0;
                        val2_q[i] <= alu_res_val;
                    end else if (lsb_res_done && lsb_res_rob_pos == q2_q[i]) begin
                        dep2_q[i] <= 1'b0;
                        val2_q[i] <= lsb_res_val;
                    end
                end
            end

            if (insertEn) begin
                busy_q[freeIdx]   <= 1'b1;
                opcode_q[freeIdx] <= issue_opcode;
                funct3_q[freeIdx] <= issue_funct3;
                funct7_q[freeIdx] <= issue_funct7;
                dep1_q[freeIdx]   <= insDep1_d;
                q1_q[freeIdx]     <= issue_q1;
                val1_q[freeIdx]   <= insVal1_d;
                dep2_q[freeIdx]   <= insDep2_d;
                q2_q[freeIdx]     <= issue_q2;
                val2_q[freeIdx]   <= insVal2_d;
                imm_q[freeIdx]    <= issue_imm;
                pc_q[freeIdx]     <= issue_pc;
                robPos_q[freeIdx] <= issue_rob_pos;
            end

            if (issueEn) begin
                busy_q[readyIdx] <= 1'b0;
                aluOpcode_q      <= opcode_q[readyIdx];
                aluFunct3_q      <= funct3_q[readyIdx];
                aluFunct7_q      <= funct7_q[readyIdx];
                aluVal1_q        <= val1_q[readyIdx];
                aluVal2_q        <= val2_q[readyIdx];
                aluImm_q         <= imm_q[readyIdx];
                aluPc_q          <= pc_q[readyIdx];
                aluRobPos_q      <= robPos_q[readyIdx];
            end

            aluEn_q  <= issueEn;
            count_q  <= count_d;
            rsFull_q <= (count_d == FULL_COUNT);
        end
    end

    assign rs_full     = rsFull_q;
    assign alu_en      = aluEn_q;
    assign alu_opcode  = aluOpcode_q;
    assign alu_funct3  = aluFunct3_q;
    assign alu_funct7  = aluFunct7_q;
    assign alu_val1    = aluVal1_q;
    assign alu_val2    = aluVal2_q;
    assign alu_imm     = aluImm_q;
    assign alu_pc      = aluPc_q;
    assign alu_rob_pos = aluRobPos_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for the ALU reservation station: a table of
// pass-through instructions plus hand-written dependency, bypass, fill,
// stall and rollback sequences.
module tb_alu_rs;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7;
        logic [31:0] val1;
        logic [31:0] val2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  robPos;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        issue_en;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic        issue_funct7;
    logic        issue_has_dep1;
    logic [3:0]  issue_q1;
    logic [31:0] issue_val1;
    logic        issue_has_dep2;
    logic [3:0]  issue_q2;
    logic [31:0] issue_val2;
    logic [31:0] issue_imm;
    logic [3:0]  issue_rob_pos;
    logic [31:0] issue_pc;
    logic        alu_res_done;
    logic [3:0]  alu_res_rob_pos;
    logic [31:0] alu_res_val;
    logic        lsb_res_done;
    logic [3:0]  lsb_res_rob_pos;
    logic [31:0] lsb_res_val;
    logic        rs_full;
    logic        alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [31:0] alu_pc;
    logic [3:0]  alu_rob_pos;

    int checks = 0;
    int errors = 0;
    vec_t vecs [8];

    alu_rs #(
        .RS_SIZE(16), .RS_IDX_WID(4), .ROB_TAG_WID(4), .DATA_WID(32)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_en(issue_en), .issue_opcode(issue_opcode),
        .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
        .issue_has_dep1(issue_has_dep1), .issue_q1(issue_q1), .issue_val1(issue_val1),
        .issue_has_dep2(issue_has_dep2), .issue_q2(issue_q2), .issue_val2(issue_val2),
        .issue_imm(issue_imm), .issue_rob_pos(issue_rob_pos), .issue_pc(issue_pc),
        .alu_res_done(alu_res_done), .alu_res_rob_pos(alu_res_rob_pos), .alu_res_val(alu_res_val),
        .lsb_res_done(lsb_res_done), .lsb_res_rob_pos(lsb_res_rob_pos), .lsb_res_val(lsb_res_val),
        .rs_full(rs_full), .alu_en(alu_en), .alu_opcode(alu_opcode),
        .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_imm(alu_imm),
        .alu_pc(alu_pc), .alu_rob_pos(alu_rob_pos)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        rollback        = 1'b0;
        issue_en        = 1'b0;
        issue_opcode    = '0;
        issue_funct3    = '0;
        issue_funct7    = 1'b0;
        issue_has_dep1  = 1'b0;
        issue_q1        = '0;
        issue_val1      = '0;
        issue_has_dep2  = 1'b0;
        issue_q2        = '0;
        issue_val2      = '0;
        issue_imm       = '0;
        issue_rob_pos   = '0;
        issue_pc        = '0;
        alu_res_done    = 1'b0;
        alu_res_rob_pos = '0;
        alu_res_val     = '0;
        lsb_res_done    = 1'b0;
        lsb_res_rob_pos = '0;
        lsb_res_val     = '0;
    endtask

    task automatic applyStimulus(input vec_t v, input logic dep1, input logic [3:0] q1,
                                 input logic dep2, input logic [3:0] q2);
        issue_en       = 1'b1;
        issue_opcode   = v.opcode;
        issue_funct3   = v.funct3;
        issue_funct7   = v.funct7;
        issue_has_dep1 = dep1;
        issue_q1       = q1;
        issue_val1     = v.val1;
        issue_has_dep2 = dep2;
        issue_q2       = q2;
        issue_val2     = v.val2;
        issue_imm      = v.imm;
        issue_pc       = v.pc;
        issue_rob_pos  = v.robPos;
    endtask

    function automatic vec_t mkVec(input logic [3:0] rob, input logic [31:0] v1, input logic [31:0] v2);
        vec_t v;
        v.opcode = 7'b0110011;
        v.funct3 = 3'd0;
        v.funct7 = 1'b0;
        v.val1   = v1;
        v.val2   = v2;
        v.imm    = 32'd0;
        v.pc     = 32'h2000 + {28'd0, rob};
        v.robPos = rob;
        return v;
    endfunction

    task automatic checkIssued(input string tag, input vec_t v);
        checkOutput({tag, "_en"},     32'(alu_en),      32'd1);
        checkOutput({tag, "_opcode"}, 32'(alu_opcode),  32'(v.opcode));
        checkOutput({tag, "_funct3"}, 32'(alu_funct3),  32'(v.funct3));
        checkOutput({tag, "_funct7"}, 32'(alu_funct7),  32'(v.funct7));
        checkOutput({tag, "_val1"},   alu_val1,         v.val1);
        checkOutput({tag, "_val2"},   alu_val2,         v.val2);
        checkOutput({tag, "_imm"},    alu_imm,          v.imm);
        checkOutput({tag, "_pc"},     alu_pc,           v.pc);
        checkOutput({tag, "_rob"},    32'(alu_rob_pos), 32'(v.robPos));
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{7'b0110011, 3'd0, 1'b0, 32'd5,        32'd7,  32'd0,        32'h100, 4'd3};
        vecs[1] = '{7'b0110011, 3'd0, 1'b1, 32'h20,       32'h8,  32'd0,        32'h104, 4'd1};
        vecs[2] = '{7'b0010011, 3'd7, 1'b0, 32'hFF00FF00, 32'd0,  32'h0F0,      32'h108, 4'd2};
        vecs[3] = '{7'b0110111, 3'd0, 1'b0, 32'd0,        32'd0,  32'h12345000, 32'h10C, 4'd4};
        vecs[4] = '{7'b0010111, 3'd0, 1'b0, 32'd0,        32'd0,  32'hABC00000, 32'h110, 4'd5};
        vecs[5] = '{7'b1100011, 3'd1, 1'b0, 32'h11,       32'h22, 32'hFFFFFFF8, 32'h114, 4'd6};
        vecs[6] = '{7'b1101111, 3'd0, 1'b0, 32'd0,        32'd0,  32'h800,      32'h118, 4'd7};
        vecs[7] = '{7'b1100111, 3'd0, 1'b0, 32'h3000,     32'd0,  32'h10,       32'h11C, 4'd15};

        clearInputs();
        rdy = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("reset_alu_en",   32'(alu_en),  32'd0);
        checkOutput("reset_rs_full",  32'(rs_full), 32'd0);
        checkOutput("reset_alu_val1", alu_val1,     32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle_alu_en", 32'(alu_en), 32'd0);
        end

        // Single ADD: inserted at edge 0, issued after edge 1, gone after edge 2
        applyStimulus(vecs[0], 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        clearInputs();
        checkOutput("add_not_yet", 32'(alu_en), 32'd0);
        tick();
        checkIssued("add", vecs[0]);
        tick();
        checkOutput("add_done", 32'(alu_en), 32'd0);

        // Back-to-back table: insert one per cycle, each issues the next edge
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) applyStimulus(vecs[i], 1'b0, 4'd0, 1'b0, 4'd0);
            else       clearInputs();
            tick();
            if (i > 0) checkIssued("table", vecs[i-1]);
        end
        tick();
        checkOutput("table_drained", 32'(alu_en), 32'd0);

        // Operand 1 waits on tag 5; a wrong-tag broadcast must not wake it
        v = mkVec(4'd4, 32'hBAD, 32'h3);
        applyStimulus(v, 1'b1, 4'd5, 1'b0, 4'd0);
        tick();
        clearInputs();
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd4; alu_res_val = 32'h99;
        tick();
        clearInputs();
        tick();
        checkOutput("dep_wrong_tag", 32'(alu_en), 32'd0);
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd5; alu_res_val = 32'h10;
        tick();
        clearInputs();
        checkOutput("dep_wake_edge", 32'(alu_en), 32'd0);
        tick();
        v.val1 = 32'h10;
        checkIssued("dep_wake", v);

        // Both operands pending, woken on different cycles via LSB then ALU
        v = mkVec(4'd8, 32'h0, 32'h0);
        applyStimulus(v, 1'b1, 4'd1, 1'b1, 4'd2);
        tick();
        clearInputs();
        lsb_res_done = 1'b1; lsb_res_rob_pos = 4'd2; lsb_res_val = 32'h222;
        tick();
        clearInputs();
        tick();
        checkOutput("two_dep_half", 32'(alu_en), 32'd0);
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd1; alu_res_val = 32'h111;
        tick();
        clearInputs();
        tick();
        v.val1 = 32'h111;
        v.val2 = 32'h222;
        checkIssued("two_dep", v);

        // Same-cycle bypass of operand 2 from the LSB bus
        v = mkVec(4'd6, 32'h1, 32'hBAD);
        applyStimulus(v, 1'b0, 4'd0, 1'b1, 4'd6);
        lsb_res_done = 1'b1; lsb_res_rob_pos = 4'd6; lsb_res_val = 32'hDEAD;
        tick();
        clearInputs();
        tick();
        v.val2 = 32'hDEAD;
        checkIssued("bypass", v);

        // rdy low: inserts ignored, then a pending issue is held off
        rdy = 1'b0;
        applyStimulus(mkVec(4'd9, 32'h9, 32'h9), 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        tick();
        clearInputs();
        rdy = 1'b1;
        checkOutput("stall_hold_en", 32'(alu_en), 32'd1);
        tick();
        tick();
        checkOutput("stall_no_insert", 32'(alu_en), 32'd0);
        v = mkVec(4'd10, 32'hA, 32'hB);
        applyStimulus(v, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        clearInputs();
        rdy = 1'b0;
        tick();
        checkOutput("stall_no_issue", 32'(alu_en), 32'd0);
        rdy = 1'b1;
        tick();
        checkIssued("stall_release", v);
        tick();

        // Fill all 16 entries waiting on tag 9
        for (int i = 0; i < 16; i++) begin
            checkOutput("fill_not_full", 32'(rs_full), 32'd0);
            applyStimulus(mkVec(4'(i), 32'd0, 32'(i)), 1'b1, 4'd9, 1'b0, 4'd0);
            tick();
        end
        clearInputs();
        checkOutput("fill_full",  32'(rs_full), 32'd1);
        checkOutput("fill_no_en", 32'(alu_en),  32'd0);
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd9; alu_res_val = 32'h900;
        tick();
        clearInputs();
        checkOutput("fill_wake_edge_en",   32'(alu_en),  32'd0);
        checkOutput("fill_wake_edge_full", 32'(rs_full), 32'd1);
        for (int k = 0; k < 16; k++) begin
            tick();
            checkOutput("drain_en",   32'(alu_en),      32'd1);
            checkOutput("drain_rob",  32'(alu_rob_pos), 32'(k));
            checkOutput("drain_val1", alu_val1,         32'h900);
            checkOutput("drain_val2", alu_val2,         32'(k));
            if (k == 0) checkOutput("drain_not_full", 32'(rs_full), 32'd0);
        end
        tick();
        checkOutput("drain_done_en",   32'(alu_en),  32'd0);
        checkOutput("drain_done_full", 32'(rs_full), 32'd0);

        // Rollback with 4 pending entries, a same-cycle insert and a wakeup
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkVec(4'(i), 32'h0, 32'h0), 1'b1, 4'd12, 1'b0, 4'd0);
            tick();
        end
        clearInputs();
        rollback = 1'b1;
        applyStimulus(mkVec(4'd7, 32'h7, 32'h7), 1'b0, 4'd0, 1'b0, 4'd0);
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd12; alu_res_val = 32'hC;
        tick();
        clearInputs();
        checkOutput("rb_en",   32'(alu_en),      32'd0);
        checkOutput("rb_full", 32'(rs_full),     32'd0);
        checkOutput("rb_rob",  32'(alu_rob_pos), 32'd0);
        checkOutput("rb_val1", alu_val1,         32'd0);
        alu_res_done = 1'b1; alu_res_rob_pos = 4'd12; alu_res_val = 32'hC;
        tick();
        clearInputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rb_quiet", 32'(alu_en), 32'd0);
        end
        v = mkVec(4'd5, 32'h55, 32'h66);
        applyStimulus(v, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        clearInputs();
        checkOutput("rb_fresh_wait", 32'(alu_en), 32'd0);
        tick();
        checkIssued("rb_fresh", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
